// File: rtl/operand_loader_pkg.sv
// Shared types and sizes for the operand loader.
// Collection states follow the A,B,C,D load order, then HOLD.
package operand_pkg;

    localparam int NIB_W = 4;
    localparam int SUM_W = NIB_W + 2;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_C = 3'd2,
        LOAD_D = 3'd3,
        HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/operand_loader_if.sv
// Producer/consumer bundle around the operand loader.
// Running_Sum exists only when RUNNING_SUM_EN is defined.
interface operand_loader_if;
    import operand_pkg::*;

    logic [NIB_W-1:0] In_Data;
    logic             In_Valid;
    logic             In_Ready;
    logic             Clear;
    logic [NIB_W-1:0] A;
    logic [NIB_W-1:0] B;
    logic [NIB_W-1:0] C;
    logic [NIB_W-1:0] D;
    logic             Ops_Valid;
    logic             Ops_Ack;
`ifdef RUNNING_SUM_EN
    logic [SUM_W-1:0] Running_Sum;
`endif

    modport master (
        output In_Data, In_Valid, Clear, Ops_Ack,
        input  In_Ready, A, B, C, D, Ops_Valid
`ifdef RUNNING_SUM_EN
        , input Running_Sum
`endif
    );

    modport slave (
        input  In_Data, In_Valid, Clear, Ops_Ack,
        output In_Ready, A, B, C, D, Ops_Valid
`ifdef RUNNING_SUM_EN
        , output Running_Sum
`endif
    );

endinterface

// File: rtl/operand_loader_op_reg.sv
// Operand nibble register: async reset, sync clear, load enable.
module op_reg #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] val_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            val_q <= '0;
        end else if (clear_i) begin
            val_q <= '0;
        end else if (load_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/operand_loader.sv
// Collects four nibbles A..D and holds them for the adder until acked.
// Optional feature macro: RUNNING_SUM_EN (adds the Running_Sum output).
module operand_loader
    import operand_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    operand_loader_if.slave  bus
);

    state_e state_q;
    logic   ops_valid_q;
    logic   loading;
    logic   xfer;
    logic   ld_a, ld_b, ld_c, ld_d;

    assign loading = (state_q != HOLD);
    assign bus.In_Ready = loading && !bus.Clear;
    assign xfer = bus.In_Valid && bus.In_Ready;

    assign ld_a = xfer && (state_q == LOAD_A);
    assign ld_b = xfer && (state_q == LOAD_B);
    assign ld_c = xfer && (state_q == LOAD_C);
    assign ld_d = xfer && (state_q == LOAD_D);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= LOAD_A;
            ops_valid_q <= 1'b0;
        end else if (bus.Clear) begin
            state_q     <= LOAD_A;
            ops_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: if (xfer) state_q <= LOAD_B;
                LOAD_B: if (xfer) state_q <= LOAD_C;
                LOAD_C: if (xfer) state_q <= LOAD_D;
                LOAD_D: begin
                    if (xfer) begin
                        state_q     <= HOLD;
                        ops_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.Ops_Ack) begin
                        state_q     <= LOAD_A;
                        ops_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= LOAD_A;
                    ops_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Ops_Valid = ops_valid_q;

    op_reg #(.W(NIB_W)) u_reg_a (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear_i (bus.Clear),
        .load_i  (ld_a),
        .d_i     (bus.In_Data),
        .q_o     (bus.A)
    );

    op_reg #(.W(NIB_W)) u_reg_b (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear_i (bus.Clear),
        .load_i  (ld_b),
        .d_i     (bus.In_Data),
        .q_o     (bus.B)
    );

    op_reg #(.W(NIB_W)) u_reg_c (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear_i (bus.Clear),
        .load_i  (ld_c),
        .d_i     (bus.In_Data),
        .q_o     (bus.C)
    );

    op_reg #(.W(NIB_W)) u_reg_d (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear_i (bus.Clear),
        .load_i  (ld_d),
        .d_i     (bus.In_Data),
        .q_o     (bus.D)
    );

`ifdef RUNNING_SUM_EN
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] nib_ext;

    assign nib_ext = {{(SUM_W-NIB_W){1'b0}}, bus.In_Data};

    // The A transfer restarts the sum so stale operands never leak in.
    always_comb begin
        sum_d = sum_q;
        if (ld_a) begin
            sum_d = nib_ext;
        end else if (xfer) begin
            sum_d = sum_q + nib_ext;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sum_q <= '0;
        end else if (bus.Clear) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.Running_Sum = sum_q;
`endif

endmodule
